// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, driven by a 16x oversampling tick.
// The line is synchronized with two flops. The start bit is checked at its
// midpoint to reject glitches. Each data bit is sampled at its midpoint. The
// receiver returns to IDLE at the middle of the stop bit, so a start edge that
// follows immediately is still caught.
//
// Ports:
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_tick       oversample tick, one i_clk cycle wide
//   i_rx         asynchronous serial line, idle high
//   o_data       last received word, LSB = first data bit
//   o_rx_done    one-cycle strobe; o_data / o_frame_err valid this cycle
//   o_frame_err  stop bit was sampled low on the last frame
//   o_busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int NB_DATA    = 8,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int NB_S = $clog2((OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK);
  localparam int NB_N = $clog2(NB_DATA);

  localparam logic [NB_S-1:0] S_MID  = NB_S'(OVERSAMPLE/2 - 1);
  localparam logic [NB_S-1:0] S_BIT  = NB_S'(OVERSAMPLE - 1);
  localparam logic [NB_S-1:0] S_STOP = NB_S'(SB_TICK - 1);
  localparam logic [NB_N-1:0] N_LAST = NB_N'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state, w_state_next;
  logic [NB_S-1:0]      r_s, w_s_next;
  logic [NB_N-1:0]      r_n, w_n_next;
  logic [NB_DATA-1:0]   r_shift, w_shift_next;
  logic [NB_DATA-1:0]   r_data, w_data_next;
  logic                 r_ferr, w_ferr_next;
  logic                 r_done, w_done_next;
  logic                 r_rx_meta, r_rx_s;

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_ferr  <= w_ferr_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_ferr_next  = r_ferr;
    w_done_next  = 1'b0;

    unique case (r_state)
      IDLE: begin
        // A tick in the same cycle as the falling edge is deliberately not counted.
        if (!r_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (r_s == S_MID) begin
            if (!r_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (r_s == S_BIT) begin
            w_s_next     = '0;
            w_shift_next = {r_rx_s, r_shift[NB_DATA-1:1]};
            if (r_n == N_LAST) w_state_next = STOP;
            else               w_n_next     = r_n + 1'b1;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (r_s == S_STOP) begin
            w_data_next  = r_shift;
            w_ferr_next  = ~r_rx_s;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_data      = r_data;
  assign o_frame_err = r_ferr;
  assign o_rx_done   = r_done;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: serial line in, parallel byte out, 8N1 frame, LSB first.
- Consumes the 16x-oversampling tick pulse from the team's baud-rate generator (one `i_clk`-wide pulse every CLK_FREQ/(BAUD_RATE*16)+1 clocks).
- Samples each bit at its midpoint and rejects start-bit glitches.
- Presents each received word with a one-cycle done strobe and a framing-error flag.

Parameters:
- NB_DATA, 8, data bits per frame.
- SB_TICK, 16, oversample ticks spanning the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OVERSAMPLE, 16, ticks per bit; must match the baud generator's divisor factor.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset.
- i_tick  in  1  oversample tick, single-cycle pulse, from the baud generator.
- i_rx  in  1  asynchronous serial line, idle high.
- o_data  out  NB_DATA  last received word, LSB = first data bit.
- o_rx_done  out  1  one-cycle strobe; o_data and o_frame_err valid this cycle.
- o_frame_err  out  1  stop bit sampled low on the last frame.
- o_busy  out  1  high while state != IDLE.

Behaviour:
- Reset: i_reset synchronous, active-high; clock i_clk.
  - On reset: state=IDLE, tick counter s=0, bit counter n=0, shift reg=0.
  - Outputs on reset: o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
  - Synchronizer flops reset to 1.
- Synchronizer: i_rx passes through a 2-FF synchronizer; rx_s is the stage-2 output. All decisions use rx_s, giving 2 clocks of latency.
- Counters: s is $clog2(max(OVERSAMPLE,SB_TICK)) bits wide. n is $clog2(NB_DATA) bits wide. Both change only on cycles with i_tick=1 or on state entry.
- IDLE:
  - If rx_s==0 → START, s=0.
  - i_tick is ignored in IDLE. A tick coincident with the falling edge is not counted.
- START: on tick:
  - If s==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 → DATA, s=0, n=0.
    - rx_s==1 → IDLE (glitch rejected, no strobe).
  - Else s++.
- DATA: on tick:
  - If s==OVERSAMPLE-1: s=0 and shift = {rx_s, shift[NB_DATA-1:1]}.
    - If n==NB_DATA-1 → STOP.
    - Else n++.
  - Else s++.
- STOP: on tick:
  - If s==SB_TICK-1 (mid stop bit for SB_TICK=16):
    - o_data <= shift.
    - o_frame_err <= ~rx_s.
    - o_rx_done <= 1 for exactly the next cycle.
    - → IDLE.
  - Else s++.
  - Return at mid stop bit so a back-to-back start edge is caught.
- Outputs:
  - o_rx_done is registered: high one clock after the sampling-tick edge, otherwise 0.
  - A strobe is issued even when a framing error occurs; o_data still loads.
  - o_data and o_frame_err hold until the next strobe.
- No tick: if i_tick stays 0, every state and counter holds indefinitely. There is no timeout.
- Line low at IDLE re-entry (framing error with the line still low): IDLE immediately goes to START. The glitch check at mid-bit decides whether a frame follows.
- Reset mid-operation: the frame is discarded with no strobe; o_data returns to 0.

Test Plan (CLK_FREQ=100 MHz, BAUD 9600: tick every 652 clocks, bit = 10432 clocks):
- Reset: hold i_reset 3 clocks with i_rx=1 → o_data=0x00, o_rx_done=0, o_frame_err=0, o_busy=0. Idle for 2 bit times: no strobe.
- Single frame: send 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) → exactly one o_rx_done pulse ~9.5 bit times after the falling edge. o_data=0x55, o_frame_err=0, o_busy falls the same cycle.
- Back-to-back: send 0xA3 then 0x0F with no idle gap between the stop and the next start → two strobes, o_data=0xA3 then 0x0F, o_frame_err=0 both times.
- Glitch: drive i_rx low for 4 ticks, then high → no strobe, o_busy returns to 0 after tick 8. A following 0x3C frame is received correctly.
- Framing error: send 0xFF with stop bit 0, then line high → strobe with o_data=0xFF, o_frame_err=1. The next frame 0x12 gives o_frame_err=0, o_data=0x12.
- Reset mid-frame: assert i_reset after 3 data bits of 0x81 → no strobe, o_busy=0, o_data=0. Resend 0x81 → received correctly.
